uart_tx_buffer: RTL and testbench

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

---
 rtl/uart_tx_buffer.sv | 101 ++++++++++
 tb/tb_uart_tx_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART transmitter: buffers host writes and hands one byte
// at a time to the transmitter through a send/active/done handshake.
module uart_tx_buffer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    tx_active_flag,
  input  logic                    tx_done_flag,
  output logic                    send,
  output logic [DATA_WIDTH-1:0]   data_in,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic                    push;
  logic                    pop;
  logic [AW:0]             count_next;

  // Pops are only launched from IDLE, so a frame consumes exactly one entry.
  always_comb begin
    push       = wr_en && !full;
    pop        = (state == IDLE) && !empty && !tx_active_flag;
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (wr_en && full) overflow <= 1'b1;
      count <= count_next;
      full  <= (count_next == CNT_FULL);
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      send    <= 1'b0;
      data_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state   <= REQ;
            send    <= 1'b1;
            data_in <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + PTR_ONE;
          end
        end
        REQ: begin
          if (tx_active_flag) begin
            state <= WAIT_DONE;
            send  <= 1'b0;
          end
        end
        WAIT_DONE: begin
          if (tx_done_flag) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          send  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: queue-based reference model compared every cycle,
// directed transfer scenarios with literal expectations, then random traffic.
module tb_uart_tx_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          tx_active_flag;
  logic          tx_done_flag;
  logic          send;
  logic [DW-1:0] data_in;
  logic          full;
  logic          empty;
  logic [3:0]    count;
  logic          overflow;

  uart_tx_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .tx_active_flag(tx_active_flag), .tx_done_flag(tx_done_flag),
    .send(send), .data_in(data_in), .full(full), .empty(empty),
    .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of pending bytes, the byte handed over, and two
  // flags meaning "request outstanding" and "frame in flight".
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_data = '0;
  bit            m_send = 0;
  bit            m_busy = 0;
  bit            m_ovf  = 0;
  bit            chk_en = 0;
  bit            do_pop;
  bit            do_push;

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      m_data = '0; m_send = 0; m_busy = 0; m_ovf = 0;
    end else begin
      do_pop  = !m_send && !m_busy && (q.size() != 0) && !tx_active_flag;
      do_push = wr_en && (q.size() != DEPTH);
      if (wr_en && q.size() == DEPTH) m_ovf = 1;
      if (do_pop) begin
        m_data = q.pop_front();
        m_send = 1;
      end else if (m_send && tx_active_flag) begin
        m_send = 0;
        m_busy = 1;
      end else if (m_busy && tx_done_flag) begin
        m_busy = 0;
      end
      if (do_push) q.push_back(wr_data);
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("m_send",     send,     m_send);
      check("m_data_in",  data_in,  m_data);
      check("m_count",    count,    q.size());
      check("m_empty",    empty,    q.size() == 0);
      check("m_full",     full,     q.size() == DEPTH);
      check("m_overflow", overflow, m_ovf);
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1; wr_en = 0; tx_active_flag = 0; tx_done_flag = 0;
    tick();
    reset = 0;
  endtask

  // Acts as the transmitter for one frame; bounded wait for send.
  task automatic transmit_one(output logic [DW-1:0] b, output bit ok);
    int n = 0;
    ok = 0; b = '0;
    while (send !== 1'b1 && n < 40) begin tick(); n++; end
    if (send === 1'b1) begin
      ok = 1; b = data_in;
      tx_active_flag = 1; tick();
      tx_active_flag = 0; tx_done_flag = 1; tick();
      tx_done_flag = 0;
    end else begin
      check("send_timeout", send, 1);
    end
  endtask

  logic [DW-1:0] got [16];
  bit            ok;

  initial begin
    reset = 1; wr_en = 0; wr_data = '0; tx_active_flag = 0; tx_done_flag = 0;
    tick();
    chk_en = 1;
    reset = 0;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_send", send, 0);
    check("rst_data_in", data_in, 0);

    // Two bytes with the transmitter idle.
    wr_en = 1; wr_data = 8'hA5; tick();
    check("a5_count", count, 1);
    wr_data = 8'h3C; tick();
    wr_en = 0;
    check("a5_send", send, 1);
    check("a5_data", data_in, 8'hA5);
    tx_active_flag = 1; tick();
    check("a5_send_low", send, 0);
    tick(); tick();
    tx_active_flag = 0; tx_done_flag = 1; tick();
    tx_done_flag = 0; tick();
    check("3c_send", send, 1);
    check("3c_data", data_in, 8'h3C);
    check("3c_empty", empty, 1);
    tx_active_flag = 1; tick();
    tx_active_flag = 0; tx_done_flag = 1; tick();
    tx_done_flag = 0;

    // Nine writes into an eight-entry FIFO with the transmitter busy.
    do_reset();
    tx_active_flag = 1;
    for (int i = 0; i < 9; i++) begin
      wr_en = 1; wr_data = 8'(i + 1); tick();
      if (i == 7) check("ovf_full_at_8", full, 1);
    end
    wr_en = 0;
    check("ovf_full", full, 1);
    check("ovf_count", count, 8);
    check("ovf_flag", overflow, 1);
    tx_active_flag = 0;
    for (int k = 0; k < 8; k++) begin
      transmit_one(got[k], ok);
      if (ok) check("ovf_order", got[k], k + 1);
    end
    repeat (5) tick();
    check("ovf_no_ninth", send, 0);
    check("ovf_drained", empty, 1);
    check("ovf_sticky", overflow, 1);

    // Concurrent writes and pops across pointer wrap, 16 bytes total.
    do_reset();
    tx_active_flag = 1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; wr_data = 8'(8'h40 + i); tick();
    end
    wr_en = 0; tx_active_flag = 0;
    fork
      begin
        for (int i = 3; i < 16; i++) begin
          wr_en = 1; wr_data = 8'(8'h40 + i); tick();
          wr_en = 0; tick(); tick(); tick();
        end
      end
      begin
        for (int k = 0; k < 16; k++) transmit_one(got[k], ok);
      end
    join
    for (int k = 0; k < 16; k++) check("wrap_order", got[k], 8'h40 + k);
    check("wrap_empty", empty, 1);

    // Request held while the transmitter stays idle.
    do_reset();
    wr_en = 1; wr_data = 8'h5A; tick();
    wr_en = 0; tick();
    check("hold_send", send, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_send_5", send, 1);
      check("hold_data_5", data_in, 8'h5A);
    end
    tx_active_flag = 1; tick();
    check("hold_ack", send, 0);
    tx_active_flag = 0; tx_done_flag = 1; tick();
    tx_done_flag = 0;

    // Reset while a frame is in flight with four bytes queued.
    do_reset();
    tx_active_flag = 1;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_data = 8'(8'h10 + i); tick();
    end
    wr_en = 0; tx_active_flag = 0; tick();
    tx_active_flag = 1; tick();
    check("mid_count", count, 4);
    check("mid_send", send, 0);
    tx_active_flag = 0; reset = 1; tick();
    reset = 0;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_send", send, 0);
    check("mid_rst_ovf", overflow, 0);
    tx_done_flag = 1; tick();
    tx_done_flag = 0; tick();
    check("mid_no_pop_send", send, 0);
    check("mid_no_pop_count", count, 0);

    // Stray done pulse while idle and empty.
    tx_done_flag = 1; tick();
    tx_done_flag = 0;
    check("idle_done_send", send, 0);
    check("idle_done_empty", empty, 1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(63) == 0);
      wr_en          = ($urandom_range(99) < 45);
      wr_data        = 8'($urandom);
      tx_active_flag = ($urandom_range(99) < 30);
      tx_done_flag   = ($urandom_range(99) < 30);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
